// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: main control FSM of the RISC_PROC multi-cycle core.
// Sequences the shared datapath through FETCH/DECODE/EXEC/MEM/WB. The opcode,
// function and shift-direction fields are latched on the DECODE edge, so the
// EXEC/MEM/WB controls are immune to later opcode changes. DECODE itself reacts
// to the live opcode, which is valid in the cycle after the IR write.
// Optional feature: define MULTI_CYCLE_CTRL_RETIRE_CNT_EN to add the 32-bit
// instRetired counter output.
module multi_cycle_ctrl #(
   parameter bit IDLE_ON_HALT = 1'b0
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       run,
   input  logic [3:0] opcode,
   input  logic [2:0] funcIn,
   input  logic       shiftDirIn,
   input  logic       zero,
   input  logic       memReady,
   output logic [2:0] aluOp,
   output logic [2:0] func,
   output logic       shiftDirection,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic       pcWrite,
   output logic       irWrite,
   output logic       memRead,
   output logic       memWrite,
   output logic       regWrite,
   output logic       iorD,
   output logic       regDst,
   output logic       memToReg,
   output logic [1:0] pcSrc,
   output logic       busy,
   output logic       illegal
`ifdef MULTI_CYCLE_CTRL_RETIRE_CNT_EN
   ,
   output logic [31:0] instRetired
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_e;

   localparam logic [3:0] OP_R     = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h1;
   localparam logic [3:0] OP_SHIFT = 4'h2;
   localparam logic [3:0] OP_LW    = 4'h3;
   localparam logic [3:0] OP_SW    = 4'h4;
   localparam logic [3:0] OP_BEQ   = 4'h5;
   localparam logic [3:0] OP_SLTI  = 4'h6;
   localparam logic [3:0] OP_JMP   = 4'h7;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_FUNC  = 3'd2;
   localparam logic [2:0] ALU_SHIFT = 3'd3;
   localparam logic [2:0] ALU_CMP   = 3'd4;

   state_e     state_q, state_d;
   logic [3:0] opcode_q, opcode_d;
   logic [2:0] func_q, func_d;
   logic       shift_dir_q, shift_dir_d;

   // 8..E are unassigned; F is HALT and handled separately.
   logic       op_illegal;
   assign op_illegal = opcode[3] && (opcode != OP_HALT);

   // State register and latched instruction fields
   always_ff @(posedge clk or negedge resetN) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      if (!resetN) begin
         state_q     <= S_IDLE;
         opcode_q    <= 4'h0;
         func_q      <= 3'd0;
         shift_dir_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         opcode_q    <= opcode_d;
         func_q      <= func_d;
         shift_dir_q <= shift_dir_d;
      end
   end

   // Next-state logic and field capture in DECODE
   always_comb begin
      // NOTE: hold-value defaults first; any path that skips an assignment would infer a latch.
      state_d     = state_q;
      opcode_d    = opcode_q;
      func_d      = func_q;
      shift_dir_d = shift_dir_q;
      case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH:  if (memReady) state_d = S_DECODE;
         S_DECODE: begin
            opcode_d    = opcode;
            func_d      = funcIn;
            shift_dir_d = shiftDirIn;
            if (opcode == OP_JMP || op_illegal) state_d = S_FETCH;
            else if (opcode == OP_HALT)         state_d = S_HALT;
            else                                state_d = S_EXEC;
         end
         S_EXEC: begin
            if (opcode_q == OP_BEQ)                         state_d = S_FETCH;
            else if (opcode_q == OP_LW || opcode_q == OP_SW) state_d = S_MEM;
            else                                            state_d = S_WB;
         end
         S_MEM: begin
            if (memReady) state_d = (opcode_q == OP_SW) ? S_FETCH : S_WB;
         end
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = IDLE_ON_HALT ? S_IDLE : S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   // Moore-style datapath controls, qualified by memReady/zero where defined
   always_comb begin
      aluOp          = ALU_ADD;
      func           = 3'd0;
      shiftDirection = 1'b0;
      aluSrcA        = 1'b0;
      aluSrcB        = 2'd0;
      pcWrite        = 1'b0;
      irWrite        = 1'b0;
      memRead        = 1'b0;
      memWrite       = 1'b0;
      regWrite       = 1'b0;
      iorD           = 1'b0;
      regDst         = 1'b0;
      memToReg       = 1'b0;
      pcSrc          = 2'd0;
      busy           = 1'b0;
      illegal        = 1'b0;
      if (state_q != S_IDLE && state_q != S_HALT) begin
         busy           = 1'b1;
         func           = func_q;
         shiftDirection = shift_dir_q;
      end
      case (state_q)
         S_FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'd2;
            irWrite = memReady;
            pcWrite = memReady;
         end
         S_DECODE: begin
            if (opcode == OP_JMP) begin
               pcWrite = 1'b1;
               pcSrc   = 2'd2;
            end
            illegal = op_illegal;
         end
         S_EXEC: begin
            aluSrcA = 1'b1;
            aluSrcB = (opcode_q == OP_R || opcode_q == OP_SHIFT) ? 2'd0 : 2'd1;
            case (opcode_q)
               OP_R:     aluOp = ALU_FUNC;
               OP_SHIFT: aluOp = ALU_SHIFT;
               OP_BEQ:   aluOp = ALU_SUB;
               OP_SLTI:  aluOp = ALU_CMP;
               default:  aluOp = ALU_ADD;
            endcase
            if (opcode_q == OP_BEQ) begin
               pcWrite = zero;
               pcSrc   = 2'd1;
            end
         end
         S_MEM: begin
            iorD     = 1'b1;
            memRead  = (opcode_q == OP_LW);
            memWrite = (opcode_q == OP_SW);
         end
         S_WB: begin
            regWrite = 1'b1;
            regDst   = (opcode_q == OP_R || opcode_q == OP_SHIFT);
            memToReg = (opcode_q == OP_LW);
         end
         default: ;
      endcase
   end

`ifdef MULTI_CYCLE_CTRL_RETIRE_CNT_EN
   logic        retire;
   logic [31:0] retired_q, retired_d;

   // Flag the final-state exit of each instruction (HALT never retires)
   always_comb begin
      retire = 1'b0;
      case (state_q)
         S_DECODE: retire = (opcode == OP_JMP) || op_illegal;
         S_EXEC:   retire = (opcode_q == OP_BEQ);
         S_MEM:    retire = memReady && (opcode_q == OP_SW);
         S_WB:     retire = 1'b1;
         default:  retire = 1'b0;
      endcase
      retired_d = retire ? retired_q + 32'd1 : retired_q;
   end

   // Retired-instruction counter, wraps at 2^32
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) retired_q <= 32'd0;
      else         retired_q <= retired_d;
   end

   assign instRetired = retired_q;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl. The stimulus process drives inputs
// just after each rising edge and queues the hand-derived output vector for
// that cycle; the monitor pops one entry per falling edge and compares.
module tb_multi_cycle_ctrl;

   typedef struct packed {
      logic [2:0] alu_op;
      logic [2:0] func;
      logic       shift_dir;
      logic       src_a;
      logic [1:0] src_b;
      logic       pc_write;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       iord;
      logic       reg_dst;
      logic       mem_to_reg;
      logic [1:0] pc_src;
      logic       busy;
      logic       illegal;
   } ctl_t;

   typedef struct {
      string nm;
      ctl_t  e;
      int    ret;
   } sb_t;

   logic       clk;
   logic       resetN;
   logic       run;
   logic [3:0] opcode;
   logic [2:0] funcIn;
   logic       shiftDirIn;
   logic       zero;
   logic       memReady;
   logic [2:0] aluOp, func, pcSrc_unused;
   logic       shiftDirection, aluSrcA, pcWrite, irWrite, memRead, memWrite;
   logic       regWrite, iorD, regDst, memToReg, busy, illegal;
   logic [1:0] aluSrcB, pcSrc;
`ifdef MULTI_CYCLE_CTRL_RETIRE_CNT_EN
   logic [31:0] instRetired;
`endif

   int   checks   = 0;
   int   failures = 0;
   sb_t  sb[$];
   ctl_t act;

   assign pcSrc_unused = 3'd0;

   multi_cycle_ctrl dut (
      .clk            (clk),
      .resetN         (resetN),
      .run            (run),
      .opcode         (opcode),
      .funcIn         (funcIn),
      .shiftDirIn     (shiftDirIn),
      .zero           (zero),
      .memReady       (memReady),
      .aluOp          (aluOp),
      .func           (func),
      .shiftDirection (shiftDirection),
      .aluSrcA        (aluSrcA),
      .aluSrcB        (aluSrcB),
      .pcWrite        (pcWrite),
      .irWrite        (irWrite),
      .memRead        (memRead),
      .memWrite       (memWrite),
      .regWrite       (regWrite),
      .iorD           (iorD),
      .regDst         (regDst),
      .memToReg       (memToReg),
      .pcSrc          (pcSrc),
      .busy           (busy),
      .illegal        (illegal)
`ifdef MULTI_CYCLE_CTRL_RETIRE_CNT_EN
      ,
      .instRetired    (instRetired)
`endif
   );

   assign act = {aluOp, func, shiftDirection, aluSrcA, aluSrcB, pcWrite, irWrite,
                 memRead, memWrite, regWrite, iorD, regDst, memToReg, pcSrc, busy, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected-vector builders, one per state, taken from the control table
   function automatic ctl_t x_off();
      ctl_t c;
      c = '0;
      return c;
   endfunction

   function automatic ctl_t x_fetch(input logic rdy, input logic [2:0] f, input logic d);
      ctl_t c;
      c = '0;
      c.mem_read = 1'b1; c.src_b = 2'd2; c.ir_write = rdy; c.pc_write = rdy;
      c.busy = 1'b1; c.func = f; c.shift_dir = d;
      return c;
   endfunction

   function automatic ctl_t x_decode(input logic [2:0] f, input logic d, input logic jmp,
                                     input logic ill);
      ctl_t c;
      c = '0;
      c.busy = 1'b1; c.func = f; c.shift_dir = d; c.illegal = ill;
      if (jmp) begin
         c.pc_write = 1'b1;
         c.pc_src   = 2'd2;
      end
      return c;
   endfunction

   function automatic ctl_t x_exec(input logic [2:0] f, input logic d, input logic [1:0] srcb,
                                   input logic [2:0] aop, input logic pcw, input logic [1:0] psrc);
      ctl_t c;
      c = '0;
      c.busy = 1'b1; c.func = f; c.shift_dir = d; c.src_a = 1'b1; c.src_b = srcb;
      c.alu_op = aop; c.pc_write = pcw; c.pc_src = psrc;
      return c;
   endfunction

   function automatic ctl_t x_mem(input logic [2:0] f, input logic d, input logic rd,
                                  input logic wr);
      ctl_t c;
      c = '0;
      c.busy = 1'b1; c.func = f; c.shift_dir = d; c.iord = 1'b1;
      c.mem_read = rd; c.mem_write = wr;
      return c;
   endfunction

   function automatic ctl_t x_wb(input logic [2:0] f, input logic d, input logic dst,
                                 input logic m2r);
      ctl_t c;
      c = '0;
      c.busy = 1'b1; c.func = f; c.shift_dir = d; c.reg_write = 1'b1;
      c.reg_dst = dst; c.mem_to_reg = m2r;
      return c;
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%h expected 0x%h", nm, got, exp);
      end
   endtask

   // Queue this cycle's expectation, then advance to just after the next edge
   task automatic cyc(input string nm, input ctl_t e, input int ret = -1);
      sb.push_back('{nm: nm, e: e, ret: ret});
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare one queued expectation per cycle, mid-cycle
   always @(negedge clk) begin
      sb_t s;
      if (sb.size() > 0) begin
         s = sb.pop_front();
         check(s.nm, {10'd0, act}, {10'd0, s.e});
`ifdef MULTI_CYCLE_CTRL_RETIRE_CNT_EN
         if (s.ret >= 0) check({s.nm, "_retired"}, instRetired, s.ret[31:0]);
`endif
      end
   end

   initial begin
      resetN = 1'b0; run = 1'b0; opcode = 4'h0; funcIn = 3'd0;
      shiftDirIn = 1'b0; zero = 1'b0; memReady = 1'b0;
      @(posedge clk);
      #1;

      // Reset state, then start
      cyc("rst0", x_off(), 0);
      cyc("rst1", x_off(), 0);
      resetN = 1'b1; run = 1'b1;
      cyc("idle", x_off(), 0);
      run = 1'b0;

      // R-type, func 5
      opcode = 4'h0; funcIn = 3'd5; shiftDirIn = 1'b0; memReady = 1'b1;
      cyc("r_fetch",  x_fetch(1'b1, 3'd0, 1'b0));
      cyc("r_decode", x_decode(3'd0, 1'b0, 1'b0, 1'b0));
      cyc("r_exec",   x_exec(3'd5, 1'b0, 2'd0, 3'd2, 1'b0, 2'd0));
      cyc("r_wb",     x_wb(3'd5, 1'b0, 1'b1, 1'b0));

      // LW with three wait cycles in MEM
      opcode = 4'h3; funcIn = 3'd2;
      cyc("lw_fetch",  x_fetch(1'b1, 3'd5, 1'b0));
      cyc("lw_decode", x_decode(3'd5, 1'b0, 1'b0, 1'b0));
      cyc("lw_exec",   x_exec(3'd2, 1'b0, 2'd1, 3'd0, 1'b0, 2'd0));
      memReady = 1'b0;
      for (int i = 0; i < 3; i++) cyc("lw_mem_wait", x_mem(3'd2, 1'b0, 1'b1, 1'b0));
      memReady = 1'b1;
      cyc("lw_mem_done", x_mem(3'd2, 1'b0, 1'b1, 1'b0));
      cyc("lw_wb",       x_wb(3'd2, 1'b0, 1'b0, 1'b1));

      // BEQ taken, then not taken
      opcode = 4'h5; funcIn = 3'd0; zero = 1'b1;
      cyc("beq1_fetch",  x_fetch(1'b1, 3'd2, 1'b0));
      cyc("beq1_decode", x_decode(3'd2, 1'b0, 1'b0, 1'b0));
      cyc("beq1_exec",   x_exec(3'd0, 1'b0, 2'd1, 3'd1, 1'b1, 2'd1));
      zero = 1'b0;
      cyc("beq0_fetch",  x_fetch(1'b1, 3'd0, 1'b0));
      cyc("beq0_decode", x_decode(3'd0, 1'b0, 1'b0, 1'b0));
      cyc("beq0_exec",   x_exec(3'd0, 1'b0, 2'd1, 3'd1, 1'b0, 2'd1));

      // SHIFT left with a fetch stall; opcode flips to 0 during EXEC
      opcode = 4'h2; funcIn = 3'd1; shiftDirIn = 1'b1; memReady = 1'b0;
      cyc("sh_fetch_wait", x_fetch(1'b0, 3'd0, 1'b0));
      memReady = 1'b1;
      cyc("sh_fetch",  x_fetch(1'b1, 3'd0, 1'b0));
      cyc("sh_decode", x_decode(3'd0, 1'b0, 1'b0, 1'b0));
      opcode = 4'h0; zero = 1'b1;
      cyc("sh_exec",   x_exec(3'd1, 1'b1, 2'd0, 3'd3, 1'b0, 2'd0));
      zero = 1'b0;
      cyc("sh_wb",     x_wb(3'd1, 1'b1, 1'b1, 1'b0));

      // Illegal opcode 9, then JMP
      opcode = 4'h9; funcIn = 3'd0; shiftDirIn = 1'b0;
      cyc("ill_fetch",  x_fetch(1'b1, 3'd1, 1'b1));
      cyc("ill_decode", x_decode(3'd1, 1'b1, 1'b0, 1'b1));
      opcode = 4'h7;
      cyc("jmp_fetch",  x_fetch(1'b1, 3'd0, 1'b0));
      cyc("jmp_decode", x_decode(3'd0, 1'b0, 1'b1, 1'b0));

      // Reset mid-FETCH, then JMP, SW, BEQ for the retire count
      resetN = 1'b0;
      cyc("rstB", x_off(), 0);
      resetN = 1'b1; run = 1'b1;
      cyc("idleB", x_off(), 0);
      run = 1'b0;
      opcode = 4'h7;
      cyc("b_jmp_fetch",  x_fetch(1'b1, 3'd0, 1'b0), 0);
      cyc("b_jmp_decode", x_decode(3'd0, 1'b0, 1'b1, 1'b0));
      opcode = 4'h4;
      cyc("b_sw_fetch",  x_fetch(1'b1, 3'd0, 1'b0), 1);
      cyc("b_sw_decode", x_decode(3'd0, 1'b0, 1'b0, 1'b0));
      cyc("b_sw_exec",   x_exec(3'd0, 1'b0, 2'd1, 3'd0, 1'b0, 2'd0));
      cyc("b_sw_mem",    x_mem(3'd0, 1'b0, 1'b0, 1'b1));
      opcode = 4'h5;
      cyc("b_beq_fetch",  x_fetch(1'b1, 3'd0, 1'b0), 2);
      cyc("b_beq_decode", x_decode(3'd0, 1'b0, 1'b0, 1'b0));
      cyc("b_beq_exec",   x_exec(3'd0, 1'b0, 2'd1, 3'd1, 1'b0, 2'd1));

      // SW held in MEM, reset asserted mid-access
      opcode = 4'h4;
      cyc("swr_fetch",  x_fetch(1'b1, 3'd0, 1'b0), 3);
      cyc("swr_decode", x_decode(3'd0, 1'b0, 1'b0, 1'b0));
      cyc("swr_exec",   x_exec(3'd0, 1'b0, 2'd1, 3'd0, 1'b0, 2'd0));
      memReady = 1'b0;
      cyc("swr_mem",    x_mem(3'd0, 1'b0, 1'b0, 1'b1), 3);
      resetN = 1'b0;
      cyc("swr_reset",  x_off(), 0);

      // HALT is terminal with the default configuration
      resetN = 1'b1; run = 1'b1; memReady = 1'b1; opcode = 4'hF;
      cyc("idleC", x_off(), 0);
      run = 1'b0;
      cyc("halt_fetch",  x_fetch(1'b1, 3'd0, 1'b0));
      cyc("halt_decode", x_decode(3'd0, 1'b0, 1'b0, 1'b0));
      run = 1'b1;
      for (int i = 0; i < 20; i++) cyc("halt_hold", x_off(), 0);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: pending %0d expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
